// File: rtl/vector_decode_sequencer.sv
// vector_decode_sequencer: classifies instructions and issues vector opcodes as N/LPC lane beats.
module vector_decode_sequencer #(
  parameter int N   = 4,
  parameter int LPC = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       instr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [15:0]                       out_class,
  output logic [31:0]                       out_instr,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] out_lane_base,
  output logic                              out_last,
  output logic                              out_illegal,
  input  logic                              flush,
  output logic                              busy
);
  localparam int LW = N > 1 ? $clog2(N) : 1;
  localparam logic [LW-1:0] STEP = LW'(LPC);
  localparam logic [LW-1:0] LAST_LANE = LW'(N - LPC);
  localparam logic MULTI = (N != LPC);
  typedef enum logic [1:0] {IDLE, ISSUE, SEQ} state_e;
  state_e         state_q;
  logic [15:0]    class_q, class_d;
  logic [31:0]    instr_q;
  logic [LW-1:0]  lane_q, lane_d;
  logic           last_q, illegal_q, vec_d;
  always_comb begin
    class_d = '0;
    case (instr[6:0])
      7'd51:  class_d[0]  = 1'b1;
      7'd19:  class_d[1]  = 1'b1;
      7'd3:   class_d[2]  = 1'b1;
      7'd35:  class_d[3]  = 1'b1;
      7'd99:  class_d[4]  = 1'b1;
      7'd111: class_d[5]  = 1'b1;
      7'd103: class_d[6]  = 1'b1;
      7'd55:  class_d[7]  = 1'b1;
      7'd23:  class_d[8]  = 1'b1;
      7'd115: class_d[9]  = 1'b1;
      7'd120: class_d[10] = 1'b1;
      7'd121: class_d[11] = 1'b1;
      7'd122: class_d[12] = 1'b1;
      7'd123: class_d[13] = 1'b1;
      7'd124: class_d[14] = 1'b1;
      7'd125: class_d[15] = 1'b1;
      default: class_d = '0;
    endcase
  end
  assign vec_d         = MULTI && (|class_d[15:10]);
  assign lane_d        = lane_q + STEP;
  assign out_valid     = (state_q != IDLE);
  assign busy          = (state_q == SEQ);
  assign in_ready      = !flush && (!out_valid || (out_ready && out_last));
  assign out_class     = class_q;
  assign out_instr     = instr_q;
  assign out_lane_base = lane_q;
  assign out_last      = last_q;
  assign out_illegal   = illegal_q;
  // Acceptance takes priority over a plain handshake: it only happens when the final beat retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      class_q   <= '0;
      instr_q   <= '0;
      lane_q    <= '0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else if (in_valid && in_ready) begin
      class_q   <= class_d;
      instr_q   <= instr;
      lane_q    <= '0;
      illegal_q <= (class_d == '0);
      last_q    <= !vec_d;
      state_q   <= vec_d ? SEQ : ISSUE;
    end else if (out_valid && out_ready) begin
      if (state_q == SEQ) begin
        lane_q  <= lane_d;
        last_q  <= (lane_d == LAST_LANE);
        state_q <= (lane_d == LAST_LANE) ? ISSUE : SEQ;
      end else begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vector_decode_sequencer.sv
// tb_vector_decode_sequencer: table-driven decode vectors with a beat scoreboard, plus stall/flush/reset sequences.
module tb_vector_decode_sequencer;
  localparam int N = 4;
  localparam int LPC = 1;
  localparam int BEATS = N / LPC;
  typedef struct {
    logic [31:0] ins;
    logic [15:0] cls;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [15:0] cls;
    logic [31:0] ins;
    logic [1:0]  lane;
    logic        last;
    logic        ill;
    logic        bsy;
  } beat_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, out_last, out_illegal, busy;
  logic [15:0] out_class;
  logic [31:0] out_instr;
  logic [1:0]  out_lane_base;
  logic [15:0] cur_cls;
  logic        cur_ill;
  int          n_chk = 0, n_fail = 0;
  beat_t       q[$];
  vec_t        tbl[18];
  int          opc[16] = '{51, 19, 3, 35, 99, 111, 103, 55, 23, 115, 120, 121, 122, 123, 124, 125};

  vector_decode_sequencer #(.N(N), .LPC(LPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_instr(out_instr),
    .out_lane_base(out_lane_base), .out_last(out_last), .out_illegal(out_illegal),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n || flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          beat_t e;
          e = q.pop_front();
          chk("out_class", {16'd0, out_class}, {16'd0, e.cls});
          chk("out_instr", out_instr, e.ins);
          chk("out_lane_base", {30'd0, out_lane_base}, {30'd0, e.lane});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          chk("busy", {31'd0, busy}, {31'd0, e.bsy});
          chk("in_ready_vs_last", {31'd0, in_ready}, {31'd0, e.last});
        end
      end
      if (in_valid && in_ready) begin
        int nb;
        nb = (cur_cls[15:10] != 0) ? BEATS : 1;
        for (int i = 0; i < nb; i++) begin
          beat_t b;
          b.cls = cur_cls; b.ins = instr; b.lane = 2'(i * LPC);
          b.last = (i == nb - 1); b.ill = cur_ill; b.bsy = (i != nb - 1);
          q.push_back(b);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [15:0] cls, input logic ill);
    int n = 0;
    instr = ins; cur_cls = cls; cur_ill = ill; in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    chk("drain_timeout", {31'd0, (n >= 100)}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_class"}, {16'd0, out_class}, 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_lane"}, {30'd0, out_lane_base}, 32'd0);
    chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{{$urandom_range(0, 33554431), opc[i][6:0]}, 16'(1 << i), 1'b0};
    tbl[16] = '{32'h1234_567F, 16'h0000, 1'b1};
    tbl[17] = '{32'hABCD_E000, 16'h0000, 1'b1};
    #3 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send(tbl[i].ins, tbl[i].cls, tbl[i].ill);
    drain();
    // stall beat 2 of a vector for three cycles
    out_ready = 1'b0;
    send(32'h0000_0478, 16'h0400, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_lane", {30'd0, out_lane_base}, 32'd1);
      chk("stall_class", {16'd0, out_class}, 32'h0400);
      chk("stall_instr", out_instr, 32'h0000_0478);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_last", {31'd0, out_last}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    // flush during beat 2 wins over the handshake
    out_ready = 1'b0;
    send(32'h0000_0178, 16'h0400, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_lane", {30'd0, out_lane_base}, 32'd0);
    send(32'h0000_027C, 16'h4000, 1'b0);
    drain();
    // async reset mid-sequence
    out_ready = 1'b0;
    send(32'h0000_037C, 16'h4000, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_reset_idle", {31'd0, out_valid}, 32'd0);
    // back-to-back scalars, one per cycle
    instr = 32'h0000_0033; cur_cls = 16'h0001; cur_ill = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr = {20'(k), 5'd1, opc[k % 10][6:0]};
      cur_cls = 16'(1 << (k % 10));
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
